// File: rtl/expand_key_seq_if.sv
// Feistel launch/result handshake and SRAM write port of the ExpandKey sequencer.
// master = sequencer side, slave = feistel/SRAM side.
interface expand_key_seq_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              f_start;
  logic [31:0]       f_L;
  logic [31:0]       f_R;
  logic [31:0]       f_resultl;
  logic [31:0]       f_resultr;
  logic              f_done;
  logic              mem_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_cs_l;
  logic              wr_we_l;

  modport master (
    output f_start, f_L, f_R, mem_sel, wr_addr, wr_data, wr_cs_l, wr_we_l,
    input  f_resultl, f_resultr, f_done
  );

  modport slave (
    input  f_start, f_L, f_R, mem_sel, wr_addr, wr_data, wr_cs_l, wr_we_l,
    output f_resultl, f_resultr, f_done
  );
endinterface

// File: rtl/expand_key_seq.sv
// bcrypt ExpandKey chaining sequencer: 521 chained feistel encryptions, results written to P then S.
// Optional SALT_XOR_EN: XOR alternating salt halves into the feistel inputs at each launch.
module expand_key_seq #(
  parameter int unsigned P_ARRAY_OFFSET = 4000,
  parameter int unsigned S_BASE         = 0,
  parameter int unsigned ADDR_W         = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [127:0]          salt,
  expand_key_seq_if.master      bus,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IDX_W   = 10;
  localparam int unsigned W_W     = IDX_W + 1;
  localparam int unsigned P_WORDS = 18;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(520);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_F, WR_L, WR_R, NEXT, FIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       l_q, l_d, r_q, r_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              f_start_q, f_start_d;
  logic [31:0]       f_l_q, f_l_d, f_r_q, f_r_d;
  logic              mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              wr_strb_l_q, wr_strb_l_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       salt_a, salt_b;

  // Word index w of the pass -> SRAM address (P-array first, then the S-boxes).
  function automatic logic [ADDR_W-1:0] dest(input logic [W_W-1:0] w);
    if (w < W_W'(P_WORDS))
      return ADDR_W'(P_ARRAY_OFFSET + 32'(w));
    else
      return ADDR_W'(S_BASE + 32'(w) - P_WORDS);
  endfunction

`ifdef SALT_XOR_EN
  // Even encryptions use the upper salt half, odd ones the lower half.
  always_comb begin
    salt_a = idx_d[0] ? salt[63:32] : salt[127:96];
    salt_b = idx_d[0] ? salt[31:0]  : salt[95:64];
  end
`else
  logic unused_salt;
  assign unused_salt = ^salt;
  always_comb begin
    salt_a = '0;
    salt_b = '0;
  end
`endif

  // Next state, datapath and next registered output values.
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE:
        if (start) begin
          l_d     = '0;
          r_d     = '0;
          idx_d   = '0;
          state_d = LAUNCH;
        end
      LAUNCH: state_d = WAIT_F;
      WAIT_F:
        if (bus.f_done) begin
          l_d     = bus.f_resultl;
          r_d     = bus.f_resultr;
          state_d = WR_L;
        end
      WR_L: state_d = WR_R;
      WR_R: state_d = NEXT;
      NEXT:
        if (idx_q == IDX_LAST) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LAUNCH;
        end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    f_start_d   = (state_d == LAUNCH);
    f_l_d       = f_l_q;
    f_r_d       = f_r_q;
    mem_sel_d   = (state_d == WR_L) || (state_d == WR_R);
    wr_strb_l_d = !mem_sel_d;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);

    if (state_d == LAUNCH) begin
      f_l_d = l_d ^ salt_a;
      f_r_d = r_d ^ salt_b;
    end
    if (state_d == WR_L) begin
      wr_addr_d = dest({idx_d, 1'b0});
      wr_data_d = l_d;
    end
    if (state_d == WR_R) begin
      wr_addr_d = dest({idx_d, 1'b1});
      wr_data_d = r_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      idx_q       <= '0;
      f_start_q   <= 1'b0;
      f_l_q       <= '0;
      f_r_q       <= '0;
      mem_sel_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_l_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      f_start_q   <= f_start_d;
      f_l_q       <= f_l_d;
      f_r_q       <= f_r_d;
      mem_sel_q   <= mem_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strb_l_q <= wr_strb_l_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.f_start = f_start_q;
  assign bus.f_L     = f_l_q;
  assign bus.f_R     = f_r_q;
  assign bus.mem_sel = mem_sel_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_cs_l = wr_strb_l_q;
  assign bus.wr_we_l = wr_strb_l_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/expand_key_seq.md
# expand_key_seq

Sequencer for the bcrypt ExpandKey data-chaining pass. It repeatedly launches the `feistel` Blowfish engine, chaining each 64-bit result into the next encryption, and writes every result pair back into SRAM: first the P-array, then all four S-boxes. It sits between the top-level bcrypt controller and the `feistel` block, and owns the SRAM write path while the engine is idle.

## Interface
Parameters:
- `P_ARRAY_OFFSET`, default 4000: SRAM word address of P[0].
- `S_BASE`, default 0: SRAM word address of S0[0]; S-boxes are 1024 consecutive words.
- `ADDR_W`, default 12: SRAM address width.

Ports (reset is `reset`, synchronous, active-low; clock is `clk`):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-low reset
- `start`  in  1  begin a pass; sampled only in IDLE
- `salt`  in  128  salt words; used only with SALT_XOR_EN
- `f_start`  out  1  one-cycle launch pulse to feistel
- `f_L`, `f_R`  out  32 each  feistel input halves; stable from LAUNCH until `f_done` is seen
- `f_resultl`, `f_resultr`  in  32 each  feistel outputs; valid with `f_done`
- `f_done`  in  1  feistel completion pulse
- `mem_sel`  out  1  1 = sequencer drives the SRAM port, 0 = feistel drives it
- `wr_addr`  out  ADDR_W  write address
- `wr_data`  out  32  write data
- `wr_cs_l`, `wr_we_l`  out  1 each  active-low chip select and write enable
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse at pass completion

## Operation
- States: IDLE, LAUNCH, WAIT_F, WR_L, WR_R, NEXT, FIN.
- **IDLE**: on `start`, clear L, R and idx (10-bit, 0..520), then go to LAUNCH.
- **LAUNCH**: assert `f_start` with `f_L` = L, `f_R` = R (salt-adjusted when SALT_XOR_EN is defined); go to WAIT_F.
- **WAIT_F**: hold `f_L`/`f_R`. When `f_done` is seen, latch L ← `f_resultl`, R ← `f_resultr`; go to WR_L.
- **WR_L**: `mem_sel`=1, `wr_cs_l`=0, `wr_we_l`=0, `wr_addr`=dest(2·idx), `wr_data`=L.
- **WR_R**: same strobes, `wr_addr`=dest(2·idx+1), `wr_data`=R.
- **NEXT**: if idx==520, go to FIN; else idx++ and go to LAUNCH.
- **FIN**: `done`=1 for one cycle, then IDLE.
- Address mapping dest(w), w in 0..1041:
  - w<18 → `P_ARRAY_OFFSET`+w
  - else → `S_BASE`+(w−18), truncated to ADDR_W
- Pass totals: 521 encryptions, 1042 writes (9 encryptions for P, 512 for S).
- Boundary behaviour:
  - `start` while busy is ignored.
  - `start` held high restarts the cycle after FIN returns to IDLE.
  - `f_done` in any state other than WAIT_F is ignored.
  - `mem_sel`=0 in all states except WR_L and WR_R.
- Reset mid-pass: the next edge forces IDLE and all outputs to reset values; no partial write strobe is issued after reset is sampled.

## Timing
- Reset values: `f_start` 0, `f_L`/`f_R` 0, `mem_sel` 0, `wr_addr` 0, `wr_data` 0, `wr_cs_l` 1, `wr_we_l` 1, `busy` 0, `done` 0.
- All outputs are registered or decoded from the state register; no input-to-output combinational path.
- `busy` rises the cycle after `start` is sampled and stays high through FIN inclusive.
- Per encryption: 1 (LAUNCH) + k (WAIT_F cycles including the `f_done` cycle) + 2 (writes) + 1 (NEXT) = 4+k cycles.
- Pass latency: start-sample to `done` = 1 + 521·(4+k) cycles.
- The first write occurs exactly 1 cycle after `f_done` is sampled.

## Configuration
- `SALT_XOR_EN` defined: at LAUNCH, `f_L` = L ^ saltA and `f_R` = R ^ saltB.
  - Even idx: saltA = `salt[127:96]`, saltB = `salt[95:64]`.
  - Odd idx: saltA = `salt[63:32]`, saltB = `salt[31:0]`.
  - Stored L/R (written to SRAM and chained) are the unsalted feistel results.
- `SALT_XOR_EN` undefined: `f_L`=L, `f_R`=R; the `salt` port is present but unused.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles → every output at its reset value; `busy`=0.
- **Chaining**: stub feistel returns L+1, R+2 with k=3, macro off, `start` → first writes 4000←1, 4001←2; second launch `f_L`=1, `f_R`=2; `done` after 1+521·7 = 3648 cycles.
- **Region boundary**: same stub:
  - encryption 8 writes 4016/4017
  - encryption 9 writes 0/1
  - encryption 520 writes 1022/1023
  - exactly 521 `f_start` pulses and one `done` pulse
- **Start while busy**: pulse `start` during WAIT_F and WR_R → ignored, write count unchanged. Hold `start` high through FIN → new pass begins, `busy` low for exactly 1 cycle.
- **Reset mid-pass**: assert reset in WR_L of encryption 100 → next cycle `wr_cs_l`=1, `mem_sel`=0, `busy`=0; a subsequent `start` writes 4000 first again.
- **SALT_XOR_EN**: define the macro, salt=0x00000011_00000022_00000033_00000044, identity stub (returns its inputs) → first launch `f_L`=0x11, `f_R`=0x22; writes 4000←0x11, 4001←0x22; second launch `f_L`=0x11^0x33=0x22, `f_R`=0x22^0x44=0x66.
